// File: rtl/fu_complete_arbiter_if.sv
// Completion bus between the functional units, the arbiter and the CDB consumers.
//
// The arbiter connects through the master modport (it drives req_ready and the
// broadcast side). The slave modport is the FU/CDB environment view.
//
// Signals:
//   req_valid  [NUM_FU]            FU i has a finished result
//   req_pr_idx [NUM_FU*PR_IDX_W]   dest PR index, FU i at [i*PR_IDX_W +: PR_IDX_W]
//   req_value  [NUM_FU*DATA_W]     dest value, FU i at [i*DATA_W +: DATA_W]
//   req_ready  [NUM_FU]            FU i result accepted at this edge if req_valid[i]
//   cdb_ready                      downstream can take a broadcast
//   flush                          drop all buffered results
//   cdb_valid/pr_idx/value/fu_id   broadcast slot
//   fu_free    [NUM_FU]            1-cycle pulse: FU i's result was broadcast
//   occupancy                      number of valid holding buffers
interface fu_complete_arbiter_if #(
    parameter int unsigned NUM_FU   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PR_IDX_W = 6,
    parameter int unsigned FU_ID_W  = 3
) ();
    localparam int unsigned OCC_W = $clog2(NUM_FU + 1);

    logic [NUM_FU-1:0]          req_valid;
    logic [NUM_FU*PR_IDX_W-1:0] req_pr_idx;
    logic [NUM_FU*DATA_W-1:0]   req_value;
    logic [NUM_FU-1:0]          req_ready;
    logic                       cdb_ready;
    logic                       flush;
    logic                       cdb_valid;
    logic [PR_IDX_W-1:0]        cdb_pr_idx;
    logic [DATA_W-1:0]          cdb_value;
    logic [FU_ID_W-1:0]         cdb_fu_id;
    logic [NUM_FU-1:0]          fu_free;
    logic [OCC_W-1:0]           occupancy;

    modport master (
        input  req_valid, req_pr_idx, req_value, cdb_ready, flush,
        output req_ready, cdb_valid, cdb_pr_idx, cdb_value, cdb_fu_id, fu_free, occupancy
    );

    modport slave (
        output req_valid, req_pr_idx, req_value, cdb_ready, flush,
        input  req_ready, cdb_valid, cdb_pr_idx, cdb_value, cdb_fu_id, fu_free, occupancy
    );
endinterface

// File: rtl/fu_complete_arbiter.sv
// Completion scheduler: one holding buffer per functional unit, one broadcast per
// cycle onto the CDB, per-FU back-pressure and a registered per-FU free pulse.
//
// Ports:
//   clock  in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    fu_complete_arbiter_if.master (request, broadcast, fu_free, occupancy)
//
// Configuration macro FU_ARB_RR_EN:
//   defined   - round-robin grant starting at rr_ptr, rr_ptr = g+1 after a broadcast
//   undefined - fixed priority, highest FU index wins
module fu_complete_arbiter #(
    parameter int unsigned NUM_FU   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PR_IDX_W = 6,
    parameter int unsigned FU_ID_W  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    fu_complete_arbiter_if.master bus
);
    localparam int unsigned OCC_W = $clog2(NUM_FU + 1);

    logic [NUM_FU-1:0]   buf_valid_q, buf_valid_d;
    logic [PR_IDX_W-1:0] buf_pr_q    [NUM_FU];
    logic [DATA_W-1:0]   buf_value_q [NUM_FU];
    logic [NUM_FU-1:0]   grant;
    logic [FU_ID_W-1:0]  grant_idx;
    logic                any_valid;
    logic                bcast;
    logic [NUM_FU-1:0]   ready;
    logic [NUM_FU-1:0]   capture;
    logic [NUM_FU-1:0]   fu_free_q, fu_free_d;
    logic [OCC_W-1:0]    occ_q, occ_d;

    assign any_valid = |buf_valid_q;

`ifdef FU_ARB_RR_EN
    logic [FU_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [FU_ID_W-1:0] rr_idx;
    logic               found;

    // First valid buffer at or after rr_ptr, wrapping at NUM_FU.
    always_comb begin
        grant_idx = '0;
        rr_idx    = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            rr_idx = FU_ID_W'((32'(rr_ptr_q) + k) % NUM_FU);
            if (!found && buf_valid_q[rr_idx]) begin
                found     = 1'b1;
                grant_idx = rr_idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (bcast) begin
            rr_ptr_d = (grant_idx == FU_ID_W'(NUM_FU - 1)) ? '0 : grant_idx + FU_ID_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Later (higher) indices overwrite earlier ones, so the highest valid index wins.
    always_comb begin
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            if (buf_valid_q[k]) begin
                grant_idx = FU_ID_W'(k);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (any_valid) begin
            grant[grant_idx] = 1'b1;
        end
        bcast = any_valid && bus.cdb_ready && !bus.flush;
        // A granted FU may refill in the same edge its old result leaves.
        ready = '0;
        if (!bus.flush) begin
            ready = ~buf_valid_q | (grant & {NUM_FU{bus.cdb_ready}});
        end
        capture = bus.req_valid & ready;
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        fu_free_d   = '0;
        if (bus.flush) begin
            buf_valid_d = '0;
        end else begin
            if (bcast) begin
                buf_valid_d = buf_valid_d & ~grant;
                fu_free_d   = grant;
            end
            buf_valid_d = buf_valid_d | capture;
        end
        occ_d = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            occ_d = occ_d + OCC_W'(buf_valid_d[k]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid_q <= '0;
            fu_free_q   <= '0;
            occ_q       <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            fu_free_q   <= fu_free_d;
            occ_q       <= occ_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                buf_pr_q[k]    <= '0;
                buf_value_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                if (capture[k]) begin
                    buf_pr_q[k]    <= bus.req_pr_idx[k*PR_IDX_W +: PR_IDX_W];
                    buf_value_q[k] <= bus.req_value[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        bus.req_ready  = ready;
        bus.cdb_valid  = any_valid;
        bus.cdb_pr_idx = any_valid ? buf_pr_q[grant_idx] : '0;
        bus.cdb_value  = any_valid ? buf_value_q[grant_idx] : '0;
        bus.cdb_fu_id  = grant_idx;
        bus.fu_free    = fu_free_q;
        bus.occupancy  = occ_q;
    end
endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Bench for fu_complete_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_fu_complete_arbiter;
    localparam int NFU = 6;
    localparam int PRW = 6;
    localparam int DW  = 32;

    logic clock = 1'b0;
    logic reset;

    fu_complete_arbiter_if bus ();

    fu_complete_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Behavioural model: a set of held results plus a pending free pulse.
    bit              m_valid [NFU];
    logic [PRW-1:0]  m_pr    [NFU];
    logic [DW-1:0]   m_val   [NFU];
    logic [NFU-1:0]  m_free;
`ifdef FU_ARB_RR_EN
    int              m_ptr;
`endif

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which held result the scheduling rule selects, -1 if none.
    function automatic int pick();
`ifdef FU_ARB_RR_EN
        for (int k = 0; k < NFU; k++) begin
            int idx;
            idx = (m_ptr + k) % NFU;
            if (m_valid[idx]) return idx;
        end
`else
        for (int k = NFU - 1; k >= 0; k--) begin
            if (m_valid[k]) return k;
        end
`endif
        return -1;
    endfunction

    function automatic logic [NFU-1:0] exp_ready();
        logic [NFU-1:0] r;
        int g;
        g = pick();
        for (int i = 0; i < NFU; i++) begin
            r[i] = !bus.flush && (!m_valid[i] || (i == g && bus.cdb_ready));
        end
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        int g;
        logic [NFU-1:0] rdy;
        if (!reset) begin
            for (int i = 0; i < NFU; i++) m_valid[i] = 1'b0;
            m_free = '0;
`ifdef FU_ARB_RR_EN
            m_ptr = 0;
`endif
        end else begin
            g   = pick();
            rdy = exp_ready();
            m_free = '0;
            if (bus.flush) begin
                for (int i = 0; i < NFU; i++) m_valid[i] = 1'b0;
            end else begin
                if (g >= 0 && bus.cdb_ready) begin
                    m_valid[g] = 1'b0;
                    m_free[g]  = 1'b1;
`ifdef FU_ARB_RR_EN
                    m_ptr = (g + 1) % NFU;
`endif
                end
                for (int i = 0; i < NFU; i++) begin
                    if (bus.req_valid[i] && rdy[i]) begin
                        m_valid[i] = 1'b1;
                        m_pr[i]    = bus.req_pr_idx[i*PRW +: PRW];
                        m_val[i]   = bus.req_value[i*DW +: DW];
                    end
                end
            end
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge clock) begin
        int g;
        int occ;
        logic [PRW-1:0] epr;
        logic [DW-1:0]  eval;
        g   = pick();
        occ = 0;
        for (int i = 0; i < NFU; i++) occ += int'(m_valid[i]);
        epr  = '0;
        eval = '0;
        if (g >= 0) begin
            epr  = m_pr[g];
            eval = m_val[g];
        end
        check("cdb_valid", 64'(bus.cdb_valid), 64'(g >= 0));
        check("cdb_fu_id", 64'(bus.cdb_fu_id), (g >= 0) ? 64'(g) : 64'd0);
        check("cdb_pr_idx", 64'(bus.cdb_pr_idx), 64'(epr));
        check("cdb_value", 64'(bus.cdb_value), 64'(eval));
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready()));
        check("fu_free", 64'(bus.fu_free), 64'(m_free));
        check("occupancy", 64'(bus.occupancy), 64'(occ));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(int i, logic [PRW-1:0] pr, logic [DW-1:0] v);
        bus.req_valid[i]            = 1'b1;
        bus.req_pr_idx[i*PRW +: PRW] = pr;
        bus.req_value[i*DW +: DW]    = v;
    endtask

    initial begin
        int first;
        int second;
        logic [NFU-1:0] rr_exp;

        reset          = 1'b0;
        bus.req_valid  = '0;
        bus.req_pr_idx = '0;
        bus.req_value  = '0;
        bus.cdb_ready  = 1'b1;
        bus.flush      = 1'b0;
        #3;
        check("lit_reset_ready", 64'(bus.req_ready), 64'h3f);
        check("lit_reset_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        tick();
        tick();
        reset = 1'b1;

        // All six FUs at once: six back-to-back broadcasts.
        for (int i = 0; i < NFU; i++) set_req(i, PRW'(10 + i), DW'(32'h100 + i));
        tick();
        bus.req_valid = '0;
        for (int n = 0; n < NFU; n++) begin
            @(negedge clock);
`ifdef FU_ARB_RR_EN
            first  = n;
            rr_exp = NFU'((1 << (n + 1)) - 1);
`else
            first  = NFU - 1 - n;
            rr_exp = NFU'(6'h3f & ~((1 << (NFU - 1 - n)) - 1));
`endif
            check("lit_all6_id", 64'(bus.cdb_fu_id), 64'(first));
            check("lit_all6_pr", 64'(bus.cdb_pr_idx), 64'(10 + first));
            check("lit_all6_ready", 64'(bus.req_ready), 64'(rr_exp));
            tick();
        end
        tick();

        // Hold with buffers 1 and 4 valid.
`ifdef FU_ARB_RR_EN
        first = 1; second = 4;
`else
        first = 4; second = 1;
`endif
        bus.cdb_ready = 1'b0;
        set_req(1, 6'd21, 32'hAAAA_0001);
        set_req(4, 6'd24, 32'hAAAA_0004);
        tick();
        bus.req_valid = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            check("lit_hold_id", 64'(bus.cdb_fu_id), 64'(first));
            check("lit_hold_occ", 64'(bus.occupancy), 64'd2);
            check("lit_hold_free", 64'(bus.fu_free), 64'd0);
            tick();
        end
        bus.cdb_ready = 1'b1;
        @(negedge clock);
        check("lit_rel_first", 64'(bus.cdb_fu_id), 64'(first));
        tick();
        @(negedge clock);
        check("lit_rel_free", 64'(bus.fu_free), 64'(1 << first));
        check("lit_rel_second", 64'(bus.cdb_fu_id), 64'(second));
        tick();
        tick();

        // Single result from FU 2.
        set_req(2, 6'd5, 32'h1234);
        tick();
        bus.req_valid = '0;
        @(negedge clock);
        check("lit_single_valid", 64'(bus.cdb_valid), 64'd1);
        check("lit_single_id", 64'(bus.cdb_fu_id), 64'd2);
        check("lit_single_pr", 64'(bus.cdb_pr_idx), 64'd5);
        check("lit_single_val", 64'(bus.cdb_value), 64'h1234);
        check("lit_single_occ1", 64'(bus.occupancy), 64'd1);
        tick();
        @(negedge clock);
        check("lit_single_free", 64'(bus.fu_free), 64'h04);
        check("lit_single_occ0", 64'(bus.occupancy), 64'd0);
        tick();

        // Pass-through streaming on FU 3.
        set_req(3, 6'd33, 32'h3000);
        for (int k = 1; k <= 5; k++) begin
            tick();
            set_req(3, 6'd33, DW'(32'h3000 + k));
            @(negedge clock);
            check("lit_pass_val", 64'(bus.cdb_value), 64'(32'h3000 + k - 1));
            check("lit_pass_ready", 64'(bus.req_ready[3]), 64'd1);
        end
        tick();
        bus.req_valid = '0;
        tick();
        tick();

        // Flush with four buffers valid and a new request on FU 0.
        bus.cdb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) set_req(i, PRW'(40 + i), DW'(32'h4000 + i));
        tick();
        bus.req_valid = '0;
        set_req(0, 6'd40, 32'h4000);
        bus.flush = 1'b1;
        @(negedge clock);
        check("lit_flush_ready", 64'(bus.req_ready), 64'd0);
        check("lit_flush_occ4", 64'(bus.occupancy), 64'd4);
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        @(negedge clock);
        check("lit_flush_occ0", 64'(bus.occupancy), 64'd0);
        check("lit_flush_valid", 64'(bus.cdb_valid), 64'd0);
        check("lit_flush_free", 64'(bus.fu_free), 64'd0);
        tick();

        // Asynchronous reset with three buffers valid.
        set_req(1, 6'd51, 32'h5001);
        set_req(2, 6'd52, 32'h5002);
        set_req(5, 6'd55, 32'h5005);
        tick();
        bus.req_valid = '0;
        check("lit_prerst_occ", 64'(bus.occupancy), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check("lit_rst_valid", 64'(bus.cdb_valid), 64'd0);
        check("lit_rst_occ", 64'(bus.occupancy), 64'd0);
        check("lit_rst_free", 64'(bus.fu_free), 64'd0);
        check("lit_rst_value", 64'(bus.cdb_value), 64'd0);
        check("lit_rst_ready", 64'(bus.req_ready), 64'h3f);
        tick();
        reset = 1'b1;
        bus.cdb_ready = 1'b1;
        set_req(0, 6'd60, 32'h6000);
        set_req(3, 6'd63, 32'h6003);
        tick();
        bus.req_valid = '0;
        @(negedge clock);
`ifdef FU_ARB_RR_EN
        check("lit_postrst_id", 64'(bus.cdb_fu_id), 64'd0);
`else
        check("lit_postrst_id", 64'(bus.cdb_fu_id), 64'd3);
`endif
        tick();
        tick();
        tick();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            bus.req_valid  = NFU'($urandom);
            for (int i = 0; i < NFU; i++) begin
                bus.req_pr_idx[i*PRW +: PRW] = PRW'($urandom);
                bus.req_value[i*DW +: DW]    = $urandom;
            end
            bus.cdb_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 24) == 0);
            tick();
        end
        bus.req_valid = '0;
        bus.flush     = 1'b0;
        bus.cdb_ready = 1'b1;
        for (int n = 0; n < 8; n++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
